// File: rtl/arb_mux_n_pkg.sv
// Shared definitions for the N-channel registered arbitration mux.
package arb_mux_n_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N     = 5;

  // Next channel index after idx, wrapping back to 0 past the last channel.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arb_mux_n_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, modulo N.
module rr_arbiter
  import arb_mux_n_pkg::*;
#(
  parameter int N = DEF_N,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx
);

  logic            found_s;
  logic [SELW-1:0] idx_s;

  // Scan requests from ptr upward with wrap, keeping only the first hit.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    idx_s   = '0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        idx_s = SELW'((int'(ptr) + i) % N);
        if (!found_s && req[idx_s]) begin
          gnt[idx_s] = 1'b1;
          gnt_idx    = idx_s;
          found_s    = 1'b1;
        end else begin
        end
      end
    end else begin
      gnt     = '0;
      gnt_idx = '0;
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel, WIDTH-bit registered mux with round-robin or fixed-select arbitration.
module arb_mux_n
  import arb_mux_n_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  localparam int SELW = $clog2(N)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_src,
  output logic                 sel_err
);

  logic            load_s;
  logic            sel_ok_s;
  logic            rr_en_s;
  logic [N-1:0]    rr_gnt_s;
  logic [SELW-1:0] rr_idx_s;
  logic [N-1:0]    fix_gnt_s;
  logic [N-1:0]    gnt_s;
  logic [SELW-1:0] gnt_idx_s;
  logic            xfer_s;
  logic [WIDTH-1:0] word_s;
  logic [SELW-1:0] rr_ptr_r;

  assign load_s   = !out_valid || out_ready;
  assign sel_ok_s = (32'(sel) < 32'(N));
  assign rr_en_s  = (mode == MODE_RR);

  rr_arbiter #(.N(N)) u_rr (
    .req     (in_valid),
    .ptr     (rr_ptr_r),
    .en      (rr_en_s),
    .gnt     (rr_gnt_s),
    .gnt_idx (rr_idx_s)
  );

  // Fixed-select grant: only the addressed channel, and only if that index exists.
  always_comb begin
    fix_gnt_s = '0;
    if ((mode == MODE_FIXED) && sel_ok_s) begin
      fix_gnt_s[sel] = in_valid[sel];
    end else begin
      fix_gnt_s = '0;
    end
  end

  // Pick the active grant source and qualify it by output-register space and reset.
  always_comb begin
    gnt_s     = '0;
    gnt_idx_s = '0;
    if (reset) begin
      gnt_s     = '0;
      gnt_idx_s = '0;
    end else if (mode == MODE_RR) begin
      gnt_s     = load_s ? rr_gnt_s : '0;
      gnt_idx_s = rr_idx_s;
    end else begin
      gnt_s     = load_s ? fix_gnt_s : '0;
      gnt_idx_s = sel;
    end
  end

  assign in_ready = gnt_s;
  assign xfer_s   = |(in_valid & gnt_s);

  // AND-OR data mux driven by the one-hot grant.
  always_comb begin
    word_s = '0;
    for (int k = 0; k < N; k++) begin
      word_s = word_s | (in_data[k*WIDTH +: WIDTH] & {WIDTH{gnt_s[k]}});
    end
  end

  // Output register, round-robin pointer and select-error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      sel_err   <= 1'b0;
      rr_ptr_r  <= '0;
    end else begin
      sel_err <= (mode == MODE_FIXED) && !sel_ok_s;
      if (xfer_s) begin
        out_valid <= 1'b1;
        out_data  <= word_s;
        out_src   <= gnt_idx_s;
        if (mode == MODE_RR) begin
          rr_ptr_r <= SELW'(wrap_inc(int'(gnt_idx_s), N));
        end else begin
          rr_ptr_r <= rr_ptr_r;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_n.sv
// Self-checking bench for arb_mux_n: vector table, corner sequences, random vs model.
module tb_arb_mux_n;

  localparam int W  = 8;
  localparam int N  = 5;
  localparam int SW = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_src;
  logic            sel_err;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic         m_v;
  logic [W-1:0] m_d;
  int           m_src;
  int           m_ptr;
  logic         m_se;
  logic [N-1:0] m_rdy;
  logic [N-1:0] s_rdy;

  typedef struct {
    logic       mode;
    logic [2:0] sel;
    logic [4:0] valid;
    logic       ordy;
    logic [4:0] rdy;
    logic       v;
    logic [2:0] src;
    logic [7:0] d;
    logic       se;
  } vec_t;

  vec_t tbl[19];

  arb_mux_n #(.WIDTH(W), .N(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src),
    .sel_err   (sel_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Which channel the rules say is taken now, given the model's state.
  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int ch;
    r = '0;
    if (reset) return r;
    if (m_v && !out_ready) return r;
    if (mode == 1'b0) begin
      for (int i = 0; i < N; i++) begin
        ch = (m_ptr + i) % N;
        if (in_valid[ch]) begin
          r[ch] = 1'b1;
          return r;
        end
      end
    end else if (int'(sel) < N) begin
      if (in_valid[sel]) r[sel] = 1'b1;
    end
    return r;
  endfunction

  // One clock: check in_ready mid-cycle, advance the model at the edge, check outputs.
  task automatic step();
    int g;
    @(negedge clock);
    m_rdy = model_ready();
    s_rdy = in_ready;
    chk("in_ready", 32'(in_ready), 32'(m_rdy));
    @(posedge clock);
    if (reset) begin
      m_v = 1'b0; m_d = '0; m_src = 0; m_ptr = 0; m_se = 1'b0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) if (m_rdy[k] && in_valid[k]) g = k;
      if (g >= 0) begin
        m_v = 1'b1;
        m_d = in_data[g*W +: W];
        m_src = g;
        if (mode == 1'b0) m_ptr = (g + 1) % N;
      end else if (out_ready) begin
        m_v = 1'b0;
      end
      m_se = (mode == 1'b1) && (int'(sel) >= N);
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_v));
    chk("out_data", 32'(out_data), 32'(m_d));
    chk("out_src", 32'(out_src), 32'(m_src));
    chk("sel_err", 32'(sel_err), 32'(m_se));
  endtask

  initial begin
    m_v = 1'b0; m_d = '0; m_src = 0; m_ptr = 0; m_se = 1'b0; m_rdy = '0; s_rdy = '0;

    tbl[0]  = '{1'b0, 3'd0, 5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0, 8'h10, 1'b0};
    tbl[1]  = '{1'b0, 3'd0, 5'b11111, 1'b1, 5'b00010, 1'b1, 3'd1, 8'h11, 1'b0};
    tbl[2]  = '{1'b0, 3'd0, 5'b11111, 1'b1, 5'b00100, 1'b1, 3'd2, 8'h12, 1'b0};
    tbl[3]  = '{1'b0, 3'd0, 5'b11111, 1'b1, 5'b01000, 1'b1, 3'd3, 8'h13, 1'b0};
    tbl[4]  = '{1'b0, 3'd0, 5'b11111, 1'b1, 5'b10000, 1'b1, 3'd4, 8'h14, 1'b0};
    tbl[5]  = '{1'b0, 3'd0, 5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0, 8'h10, 1'b0};
    tbl[6]  = '{1'b0, 3'd0, 5'b01010, 1'b1, 5'b00010, 1'b1, 3'd1, 8'h11, 1'b0};
    tbl[7]  = '{1'b0, 3'd0, 5'b01010, 1'b1, 5'b01000, 1'b1, 3'd3, 8'h13, 1'b0};
    tbl[8]  = '{1'b0, 3'd0, 5'b01010, 1'b1, 5'b00010, 1'b1, 3'd1, 8'h11, 1'b0};
    tbl[9]  = '{1'b0, 3'd0, 5'b01010, 1'b1, 5'b01000, 1'b1, 3'd3, 8'h13, 1'b0};
    tbl[10] = '{1'b1, 3'd6, 5'b11111, 1'b1, 5'b00000, 1'b0, 3'd3, 8'h13, 1'b1};
    tbl[11] = '{1'b1, 3'd6, 5'b11111, 1'b1, 5'b00000, 1'b0, 3'd3, 8'h13, 1'b1};
    tbl[12] = '{1'b0, 3'd0, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd3, 8'h13, 1'b0};
    tbl[13] = '{1'b1, 3'd2, 5'b11111, 1'b0, 5'b00100, 1'b1, 3'd2, 8'h12, 1'b0};
    tbl[14] = '{1'b1, 3'd2, 5'b11111, 1'b0, 5'b00000, 1'b1, 3'd2, 8'h12, 1'b0};
    tbl[15] = '{1'b1, 3'd2, 5'b11111, 1'b0, 5'b00000, 1'b1, 3'd2, 8'h12, 1'b0};
    tbl[16] = '{1'b1, 3'd2, 5'b11111, 1'b1, 5'b00100, 1'b1, 3'd2, 8'h12, 1'b0};
    tbl[17] = '{1'b0, 3'd0, 5'b11111, 1'b1, 5'b10000, 1'b1, 3'd4, 8'h14, 1'b0};
    tbl[18] = '{1'b0, 3'd0, 5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0, 8'h10, 1'b0};

    reset = 1'b1; mode = 1'b0; sel = '0; in_valid = '1; out_ready = 1'b0;
    for (int k = 0; k < N; k++) in_data[k*W +: W] = 8'(8'h10 + k);

    // reset state
    step();
    step();
    chk("rst_rdy", 32'(s_rdy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_src", 32'(out_src), 32'd0);
    chk("rst_selerr", 32'(sel_err), 32'd0);
    reset = 1'b0;

    // vector table
    for (int i = 0; i < 19; i++) begin
      mode = tbl[i].mode; sel = tbl[i].sel; in_valid = tbl[i].valid; out_ready = tbl[i].ordy;
      step();
      chk($sformatf("tbl%0d_rdy", i), 32'(s_rdy), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_src", i), 32'(out_src), 32'(tbl[i].src));
      chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].d));
      chk($sformatf("tbl%0d_selerr", i), 32'(sel_err), 32'(tbl[i].se));
    end

    // reset mid-operation with pointer at 3 and a held word
    mode = 1'b0; in_valid = 5'b00100; out_ready = 1'b1;
    step();
    chk("mid_pre_src", 32'(out_src), 32'd2);
    reset = 1'b1; in_valid = '1; out_ready = 1'b0;
    step();
    chk("mid_rst_rdy", 32'(s_rdy), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_src", 32'(out_src), 32'd0);
    reset = 1'b0; out_ready = 1'b1;
    step();
    chk("mid_first_rdy", 32'(s_rdy), 32'b00001);
    chk("mid_first_src", 32'(out_src), 32'd0);

    // fixed select with stall, then same-cycle replace
    in_valid = '0;
    step();
    mode = 1'b1; sel = 3'd2; in_valid = '1; out_ready = 1'b0;
    in_data[2*W +: W] = 8'hA5;
    step();
    chk("fix_valid", 32'(out_valid), 32'd1);
    chk("fix_data", 32'(out_data), 32'hA5);
    in_data[2*W +: W] = 8'h5A;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_rdy", 32'(s_rdy), 32'd0);
      chk("stall_data", 32'(out_data), 32'hA5);
    end
    out_ready = 1'b1;
    step();
    chk("replace_rdy", 32'(s_rdy), 32'b00100);
    chk("replace_data", 32'(out_data), 32'h5A);
    chk("replace_valid", 32'(out_valid), 32'd1);

    // randomized traffic against the model; pending words hold until taken
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < N; k++) begin
        if (!(in_valid[k] && !m_rdy[k])) begin
          in_valid[k] = 1'($urandom_range(0, 1));
          in_data[k*W +: W] = 8'($urandom);
        end
      end
      mode      = 1'($urandom_range(0, 1));
      sel       = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
